// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Access sizes, FSM states and byte-lane helper functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic [3:0] lane_enable(input access_size_t size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: lane_enable = 4'b0001 << offset;
            SZ_HALF: lane_enable = 4'b0011 << offset;
            SZ_WORD: lane_enable = 4'b1111;
            default: lane_enable = 4'b0000;
        endcase
    endfunction

    // Store data is right-justified; copying it to every lane lets the byte enables pick the target.
    function automatic logic [31:0] store_replicate(input access_size_t size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_replicate = {4{wdata[7:0]}};
            SZ_HALF: store_replicate = {2{wdata[15:0]}};
            default: store_replicate = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input access_size_t size,
                                                input logic [1:0] offset, input logic is_unsigned);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: load_extend = is_unsigned ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_extend = is_unsigned ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath-to-data-memory request/response bundle.
// master = datapath initiator, slave = memory responder.
interface dmem_responder_if;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_addr;
    logic [1:0]  ram_size;
    logic        ram_unsigned;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        ram_ready;
    logic        ram_err;

    modport master (
        output ram_read, ram_write, ram_addr, ram_size, ram_unsigned, ram_writedata,
        input  ram_readdata, ram_ready, ram_err
    );

    modport slave (
        input  ram_read, ram_write, ram_addr, ram_size, ram_unsigned, ram_writedata,
        output ram_readdata, ram_ready, ram_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word-organised data RAM with byte write enables and a registered read port.
// Contents are intentionally not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serialises datapath loads/stores onto dmem_array with wait states.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses instead of force-aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_responder_if.slave bus
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    dmem_state_t   r_state, w_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_index;
    logic [1:0]    r_lane;
    access_size_t  r_size;
    logic          r_uns;
    logic          r_write;
    logic          r_err;
    logic [31:0]   r_wdata;

    logic          w_req, w_accept, w_commit;
    access_size_t  w_size;
    logic [31:0]   w_off;
    logic [AW-1:0] w_index;
    logic [1:0]    w_lane;
    logic          w_in_range, w_err;
    logic [AW-1:0] w_c_index;
    logic [1:0]    w_c_lane;
    access_size_t  w_c_size;
    logic          w_c_write, w_c_err;
    logic [31:0]   w_c_wdata;
    logic [3:0]    w_we;
    logic [31:0]   w_rdata;

    assign w_req      = bus.ram_read | bus.ram_write;
    assign w_accept   = (r_state == IDLE) && w_req;
    assign w_size     = access_size_t'(bus.ram_size);
    assign w_off      = bus.ram_addr - BASE_ADDR;
    assign w_index    = w_off[AW+1:2];
    assign w_in_range = (bus.ram_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN_BYTES);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_lane = bus.ram_addr[1:0];
    assign w_err  = (bus.ram_read & bus.ram_write) || (w_size == SZ_RSVD) || !w_in_range ||
                    ((w_size == SZ_HALF) && bus.ram_addr[0]) ||
                    ((w_size == SZ_WORD) && (bus.ram_addr[1:0] != 2'b00));
`else
    assign w_lane = (w_size == SZ_HALF) ? {bus.ram_addr[1], 1'b0} :
                    (w_size == SZ_WORD) ? 2'b00 : bus.ram_addr[1:0];
    assign w_err  = (bus.ram_read & bus.ram_write) || (w_size == SZ_RSVD) || !w_in_range;
`endif

    // With zero wait states the commit edge is also the accept edge, so the live request is used.
    assign w_commit  = ((WAIT_CYCLES == 0) && w_accept) || ((r_state == WAIT) && (r_cnt == 4'd0));
    assign w_c_index = (r_state == IDLE) ? w_index : r_index;
    assign w_c_lane  = (r_state == IDLE) ? w_lane : r_lane;
    assign w_c_size  = (r_state == IDLE) ? w_size : r_size;
    assign w_c_write = (r_state == IDLE) ? bus.ram_write : r_write;
    assign w_c_err   = (r_state == IDLE) ? w_err : r_err;
    assign w_c_wdata = (r_state == IDLE) ? store_replicate(w_size, bus.ram_writedata) : r_wdata;
    assign w_we      = (w_c_write && !w_c_err) ? lane_enable(w_c_size, w_c_lane) : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .i_en   (w_commit),
        .i_we   (w_we),
        .i_addr (w_c_index),
        .i_wdata(w_c_wdata),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= WAIT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
            r_lane  <= 2'b00;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_index <= w_index;
            r_lane  <= w_lane;
            r_size  <= w_size;
            r_uns   <= bus.ram_unsigned;
            r_write <= bus.ram_write;
            r_err   <= w_err;
            r_wdata <= store_replicate(w_size, bus.ram_writedata);
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.ram_ready    = 1'b0;
        bus.ram_err      = 1'b0;
        bus.ram_readdata = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next        = IDLE;
                bus.ram_ready = 1'b1;
                bus.ram_err   = r_err;
                if (!r_err && !r_write) begin
                    bus.ram_readdata = load_extend(w_rdata, r_size, r_lane, r_uns);
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, randomized traffic,
// plus a second 3-wait-state instance used for the mid-transaction reset scenario.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int SPAN  = 4 * DEPTH;

    typedef struct {
        logic        err;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    logic [7:0] model [SPAN];

    always #5 clk = ~clk;

    dmem_responder_if bus();
    dmem_responder_if bus2();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    // Reference model: memory as a flat byte array, result built from byte count and extension rules.
    function automatic void modelAccess(input logic rd, input logic wr, input logic [31:0] addr,
                                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                        output logic err, output logic [31:0] data);
        int nbytes;
        int ea;
        logic [31:0] raw;
        err    = 1'b0;
        data   = 32'h0;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (rd && wr) err = 1'b1;
        if (size == 2'd3) err = 1'b1;
        if (addr >= 32'(SPAN)) err = 1'b1;
        if (err) return;
        ea = int'(addr);
`ifdef DMEM_MISALIGN_ERR_EN
        if ((ea % nbytes) != 0) begin
            err = 1'b1;
            return;
        end
`else
        ea = ea - (ea % nbytes);
`endif
        if (wr) begin
            for (int k = 0; k < nbytes; k++) model[ea + k] = wdata[8*k +: 8];
        end else begin
            raw = 32'h0;
            for (int k = 0; k < nbytes; k++) raw[8*k +: 8] = model[ea + k];
            if (nbytes < 4 && !uns && raw[8*nbytes - 1]) raw = raw | (32'hFFFF_FFFF << (8 * nbytes));
            data = raw;
        end
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input logic useExp,
                                 input logic expErr, input logic [31:0] expData, input string name);
        logic        mErr;
        logic [31:0] mData;
        exp_t        e;
        int          lat;
        logic        seen;
        modelAccess(rd, wr, addr, size, uns, wdata, mErr, mData);
        e.err  = useExp ? expErr : mErr;
        e.data = useExp ? expData : mData;
        e.name = name;
        sbq.push_back(e);
        bus.ram_read      = rd;
        bus.ram_write     = wr;
        bus.ram_addr      = addr;
        bus.ram_size      = size;
        bus.ram_unsigned  = uns;
        bus.ram_writedata = wdata;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.ram_ready) seen = 1'b1;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'd2);
        bus.ram_read  = 1'b0;
        bus.ram_write = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every ready pulse consumes one expected response.
    always @(negedge clk) begin
        if (rst_n && bus.ram_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput({e.name, " err"}, {31'h0, bus.ram_err}, {31'h0, e.err});
                checkOutput({e.name, " data"}, bus.ram_readdata, e.data);
            end
        end
    end

    task automatic run2(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] data);
        logic seen;
        bus2.ram_read      = rd;
        bus2.ram_write     = wr;
        bus2.ram_addr      = addr;
        bus2.ram_size      = 2'd2;
        bus2.ram_unsigned  = 1'b0;
        bus2.ram_writedata = wdata;
        lat  = 0;
        seen = 1'b0;
        err  = 1'b0;
        data = 32'h0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus2.ram_ready) begin
                seen = 1'b1;
                err  = bus2.ram_err;
                data = bus2.ram_readdata;
            end
        end
        bus2.ram_read  = 1'b0;
        bus2.ram_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic        err;
        logic [31:0] data;
        int          readyCount;
        logic        rd, wr;
        int          kind;
        logic [31:0] addr;
        logic [1:0]  size;

        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.ram_read = 1'b0;  bus.ram_write = 1'b0;  bus.ram_addr = 32'h0;
        bus.ram_size = 2'd0;  bus.ram_unsigned = 1'b0; bus.ram_writedata = 32'h0;
        bus2.ram_read = 1'b0; bus2.ram_write = 1'b0; bus2.ram_addr = 32'h0;
        bus2.ram_size = 2'd0; bus2.ram_unsigned = 1'b0; bus2.ram_writedata = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset ready", {31'h0, bus.ram_ready}, 32'h0);
        checkOutput("reset err", {31'h0, bus.ram_err}, 32'h0);
        checkOutput("reset readdata", bus.ram_readdata, 32'h0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 1, 0, 32'h0, "word write 0x10");
        applyStimulus(1, 0, 32'h10, 2'd2, 0, 32'h0, 1, 0, 32'hDEADBEEF, "word read 0x10");
        applyStimulus(0, 1, 32'h11, 2'd0, 0, 32'h80, 1, 0, 32'h0, "byte write 0x11");
        applyStimulus(1, 0, 32'h11, 2'd0, 0, 32'h0, 1, 0, 32'hFFFFFF80, "signed byte read");
        applyStimulus(1, 0, 32'h11, 2'd0, 1, 32'h0, 1, 0, 32'h00000080, "unsigned byte read");
        applyStimulus(1, 0, 32'h10, 2'd2, 0, 32'h0, 1, 0, 32'hDEAD80EF, "word after byte");
        applyStimulus(0, 1, 32'h12, 2'd1, 0, 32'h1234, 1, 0, 32'h0, "half write 0x12");
        applyStimulus(1, 0, 32'h12, 2'd1, 0, 32'h0, 1, 0, 32'h00001234, "signed half read");
        applyStimulus(1, 0, 32'h10, 2'd2, 0, 32'h0, 1, 0, 32'h123480EF, "word after half");
        applyStimulus(1, 0, 32'(SPAN), 2'd2, 0, 32'h0, 1, 1, 32'h0, "out of range read");
        applyStimulus(1, 1, 32'h10, 2'd2, 0, 32'h55555555, 1, 1, 32'h0, "read and write");
        applyStimulus(1, 0, 32'h10, 2'd2, 0, 32'h0, 1, 0, 32'h123480EF, "word after errors");
`ifdef DMEM_MISALIGN_ERR_EN
        applyStimulus(0, 1, 32'h13, 2'd2, 0, 32'hCAFEF00D, 1, 1, 32'h0, "misaligned word write");
        applyStimulus(1, 0, 32'h10, 2'd2, 0, 32'h0, 1, 0, 32'h123480EF, "word after misaligned");
`else
        applyStimulus(0, 1, 32'h13, 2'd2, 0, 32'hCAFEF00D, 1, 0, 32'h0, "misaligned word write");
        applyStimulus(1, 0, 32'h10, 2'd2, 0, 32'h0, 1, 0, 32'hCAFEF00D, "word after misaligned");
`endif

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 32'(i * 4), 2'd2, 0, $urandom, 0, 0, 32'h0, "init word");
        end
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 19);
            rd   = (kind <= 9);
            wr   = (kind == 0) || (kind >= 10);
            addr = ($urandom_range(0, 15) == 0) ? 32'(SPAN) + 32'($urandom_range(0, 255))
                                                : 32'($urandom_range(0, 63));
            size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(rd, wr, addr, size, 1'($urandom_range(0, 1)), $urandom, 0, 0, 32'h0, "random");
        end

        // Three-wait-state instance: reset lands between accept and the commit edge.
        run2(0, 1, 32'h20, 32'h11112222, lat, err, data);
        checkOutput("w3 write latency", 32'(lat), 32'd4);
        checkOutput("w3 write err", {31'h0, err}, 32'h0);
        bus2.ram_write = 1'b1;
        bus2.ram_addr = 32'h20;
        bus2.ram_size = 2'd2;
        bus2.ram_writedata = 32'h99999999;
        readyCount = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus2.ram_ready) readyCount++;
        end
        rst2_n = 1'b0;
        bus2.ram_write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("w3 reset outputs", {bus2.ram_readdata[31:2], bus2.ram_ready, bus2.ram_err},
                        32'h0);
        end
        rst2_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus2.ram_ready) readyCount++;
        end
        checkOutput("w3 dropped ready count", 32'(readyCount), 32'd0);
        run2(1, 0, 32'h20, 32'h0, lat, err, data);
        checkOutput("w3 read latency", 32'(lat), 32'd4);
        checkOutput("w3 read err", {31'h0, err}, 32'h0);
        checkOutput("w3 word unchanged", data, 32'h11112222);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V datapath. Serves the datapath's load/store requests (ram_read/ram_write with address, size and write data) against an on-chip word-organised RAM. Provides byte/half/word access, sign/zero extension, programmable wait states and a one-cycle ready/error response. It sits between the datapath and the data RAM, opposite the datapath's memory initiator port.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_CYCLES, 1: extra cycles between accept and response; 0–15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ram_read  in  1  load request; held until ram_ready.
- ram_write  in  1  store request; held until ram_ready.
- ram_addr  in  32  byte address; stable while the request is held.
- ram_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- ram_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
- ram_writedata  in  32  store data, right-justified.
- ram_readdata  out  32  load result; valid only with ram_ready.
- ram_ready  out  1  single-cycle completion pulse.
- ram_err  out  1  error flag; qualified by ram_ready.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - (ram_read | ram_write) latches addr, size, unsigned, wdata and the error check.
  - Goes to WAIT if WAIT_CYCLES > 0, otherwise to RESP.
- WAIT: a 4-bit counter loads WAIT_CYCLES−1 and decrements. At 0, go to RESP.
- Commit edge: the edge that enters RESP.
  - The RAM write happens here and only here.
  - The read result is registered at the same edge.
- RESP:
  - ram_ready=1 for exactly one cycle, then IDLE.
  - The initiator drops or changes its request on the edge after it sees ram_ready.
- Error conditions (ram_err=1, no RAM write, ram_readdata=0):
  - ram_read & ram_write both high;
  - ram_size==3;
  - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS);
  - misaligned access (see Configuration).
- Lane handling:
  - Word index = (addr−BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - Byte enables: byte → 1<<addr[1:0]; half → 2'b11<<addr[1:0]; word → 4'hF.
  - Store data is replicated across lanes (byte ×4, half ×2).
  - Load: the selected lane is shifted to bits [7:0]/[15:0], then extended per ram_unsigned.

## Timing
- Request sampled at edge N.
- ram_ready is high during cycle N+1+WAIT_CYCLES. Issue-to-issue minimum is 2+WAIT_CYCLES cycles.
- Reset values: ram_ready=0, ram_err=0, ram_readdata=0, FSM=IDLE, counter=0. RAM contents are not reset.
- Reset mid-operation (WAIT or before the commit edge): the transaction is dropped and no write occurs. After reset deassertion, the initiator must re-issue.
- Requests arriving while in WAIT/RESP are ignored; only the request latched in IDLE is served.
- Write followed by a read of the same address returns the new data; there is no read-during-write hazard because accesses are serialised.

## Configuration
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: these accesses complete with ram_err=1 and no RAM side effect:
  - half with addr[0]≠0;
  - word with addr[1:0]≠0.
- Undefined: low address bits are forced aligned and the access completes normally with ram_err=0:
  - half clears addr[0];
  - word clears addr[1:0].

## Structure
- Package dmem_pkg holds:
  - enum access_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD};
  - enum dmem_state_t {IDLE, WAIT, RESP};
  - function lane_enable(size, addr[1:0]);
  - function load_extend(word, size, offset, unsigned).
- Sub-module dmem_array:
  - single-port synchronous RAM, DEPTH_WORDS×32;
  - 4-bit byte write enable;
  - registered read port;
  - no reset.
- dmem_responder contains the FSM, wait counter, request latch, range/alignment check and lane logic.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10, then word read 0x10, WAIT_CYCLES=1:
  - each ram_ready arrives 2 cycles after its request;
  - the read returns 0xDEADBEEF with ram_err=0.
- After the above, byte write 0x80 to 0x11, then reads of 0x11:
  - signed byte read → 0xFFFFFF80; unsigned → 0x00000080;
  - word read of 0x10 → 0xDEAD80EF.
- Half write 0x1234 to 0x12, then signed half read of 0x12 → 0x00001234, and word read of 0x10 → 0x123480EF.
- Word read at BASE_ADDR+4*DEPTH_WORDS, and separately ram_read&ram_write both high:
  - both give ram_err=1 and ram_readdata=0;
  - a follow-up read of 0x10 shows memory unchanged.
- Word write to 0x13:
  - with DMEM_MISALIGN_ERR_EN defined: ram_err=1 and word 0x10 unchanged;
  - without it: the write lands at 0x10 and ram_err=0.
- WAIT_CYCLES=3, rst_n pulsed low 2 cycles after a write request:
  - no ram_ready pulse and the target word is unchanged;
  - all outputs are 0 during reset.
